// File: rtl/regfile_pkg.sv
// Shared sizing and word type for the 8-entry, 32-bit register file primitives.
package regfile_pkg;

    localparam int unsigned REG_WIDTH     = 32;
    localparam int unsigned NUM_REGS      = 8;
    localparam int unsigned REG_ADDR_BITS = 3;

    typedef logic [REG_WIDTH-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/mux8_to1_b32.sv
// Combinational 8:1 word selector driving one register-file read port.
module mux8_to1_b32
    import regfile_pkg::*;
(
    input  logic  S2,
    input  logic  S1,
    input  logic  S0,
    input  word_t I7,
    input  word_t I6,
    input  word_t I5,
    input  word_t I4,
    input  word_t I3,
    input  word_t I2,
    input  word_t I1,
    input  word_t I0,
    output word_t Y
);

    logic [REG_ADDR_BITS-1:0] w_sel;

    assign w_sel = {S2, S1, S0};

    // Unknown select bits fall to I0 so the read port never holds state or goes X.
    always_comb begin
        Y = I0;
        case (w_sel)
            3'd0:    Y = I0;
            3'd1:    Y = I1;
            3'd2:    Y = I2;
            3'd3:    Y = I3;
            3'd4:    Y = I4;
            3'd5:    Y = I5;
            3'd6:    Y = I6;
            3'd7:    Y = I7;
            default: Y = I0;
        endcase
    end

endmodule : mux8_to1_b32

// File: rtl/enabled_register.sv
// Width-parameterized D register with write enable and asynchronous active-low clear.
module enabled_register
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = REG_WIDTH
) (
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    input  logic             CLK,
    input  logic             EN,
    input  logic             RESET_N
);

    // Clear wins over any coincident clock edge; otherwise capture only when enabled.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            Q <= '0;
        end else if (EN) begin
            Q <= D;
        end
    end

endmodule : enabled_register

// File: tb/tb_enabled_register.sv
// Directed bench for enabled_register, mux8_to1_b32 and a small register file built from them.
module tb_enabled_register;
    import regfile_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        EN;
    logic [31:0] D;
    logic [31:0] Q;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    enabled_register #(.WIDTH(32)) dut (
        .D       (D),
        .Q       (Q),
        .CLK     (CLK),
        .EN      (EN),
        .RESET_N (RESET_N)
    );

    // Standalone mux for the select sweep
    logic [2:0] m_sel;
    word_t      m_i [8];
    word_t      m_y;

    mux8_to1_b32 u_mux (
        .S2 (m_sel[2]), .S1 (m_sel[1]), .S0 (m_sel[0]),
        .I7 (m_i[7]), .I6 (m_i[6]), .I5 (m_i[5]), .I4 (m_i[4]),
        .I3 (m_i[3]), .I2 (m_i[2]), .I1 (m_i[1]), .I0 (m_i[0]),
        .Y  (m_y)
    );

    // Register file: decode on A3[2:0] and WE3, two read ports
    logic       rf_we;
    logic [4:0] rf_a1, rf_a2, rf_a3;
    word_t      rf_wd;
    word_t      rf_q [8];
    logic [7:0] rf_en;
    word_t      rd1, rd2;

    always_comb begin
        rf_en = '0;
        for (int i = 0; i < 8; i++) begin
            rf_en[i] = rf_we && (rf_a3[2:0] == 3'(i));
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_rf
        enabled_register #(.WIDTH(32)) u_reg (
            .D       (rf_wd),
            .Q       (rf_q[g]),
            .CLK     (CLK),
            .EN      (rf_en[g]),
            .RESET_N (RESET_N)
        );
    end

    mux8_to1_b32 u_rd1 (
        .S2 (rf_a1[2]), .S1 (rf_a1[1]), .S0 (rf_a1[0]),
        .I7 (rf_q[7]), .I6 (rf_q[6]), .I5 (rf_q[5]), .I4 (rf_q[4]),
        .I3 (rf_q[3]), .I2 (rf_q[2]), .I1 (rf_q[1]), .I0 (rf_q[0]),
        .Y  (rd1)
    );

    mux8_to1_b32 u_rd2 (
        .S2 (rf_a2[2]), .S1 (rf_a2[1]), .S0 (rf_a2[0]),
        .I7 (rf_q[7]), .I6 (rf_q[6]), .I5 (rf_q[5]), .I4 (rf_q[4]),
        .I3 (rf_q[3]), .I2 (rf_q[2]), .I1 (rf_q[1]), .I0 (rf_q[0]),
        .Y  (rd2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // EN must be known at every active edge once out of reset
    always @(posedge CLK) begin
        if (RESET_N === 1'b1) begin
            compared++;
            assert (!$isunknown(EN)) else begin
                mismatched++;
                $error("FAIL en_known: observed %b expected 0/1", EN);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET_N = 1'b0;
        EN      = 1'b0;
        D       = 32'h0;
        rf_we   = 1'b0;
        rf_a1   = 5'd0;
        rf_a2   = 5'd0;
        rf_a3   = 5'd0;
        rf_wd   = 32'h0;
        m_sel   = 3'd0;
        for (int k = 0; k < 8; k++) m_i[k] = 32'h1000_0000 + 32'(k);

        #3;
        check("reset_q", Q, 32'h0);

        // Load DEADBEEF, then clear asynchronously mid-cycle
        tick();
        RESET_N = 1'b1;
        EN      = 1'b1;
        D       = 32'hDEADBEEF;
        tick();
        check("load_deadbeef", Q, 32'hDEADBEEF);
        D = 32'h12345678;
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_clear", Q, 32'h0);
        tick();
        check("reset_hold_edge1", Q, 32'h0);
        tick();
        check("reset_hold_edge2", Q, 32'h0);

        // Enable / hold
        RESET_N = 1'b1;
        D       = 32'hA5A5A5A5;
        EN      = 1'b1;
        #2;
        check("stable_between_edges", Q, 32'h0);
        tick();
        check("enable_write", Q, 32'hA5A5A5A5);
        EN = 1'b0;
        D  = 32'h0;
        tick();
        check("enable_hold", Q, 32'hA5A5A5A5);

        // Back-to-back writes
        EN = 1'b1;
        D  = 32'd1;
        tick();
        check("b2b_1", Q, 32'd1);
        D = 32'd2;
        tick();
        check("b2b_2", Q, 32'd2);
        D = 32'd3;
        tick();
        check("b2b_3", Q, 32'd3);

        // Reset coincident with a rising edge: clear wins
        D = 32'd4;
        @(posedge CLK);
        RESET_N = 1'b0;
        #1;
        check("reset_with_edge", Q, 32'h0);
        RESET_N = 1'b1;
        tick();
        check("first_capture_after_reset", Q, 32'd4);

        // Mux sweep
        for (int s = 0; s < 8; s++) begin
            m_sel = 3'(s);
            #1;
            check($sformatf("mux_sel%0d", s), m_y, 32'h1000_0000 + 32'(s));
        end

        // Register file: preload reg k with 0x100+k
        rf_we = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rf_a3 = 5'(k);
            rf_wd = 32'h100 + 32'(k);
            tick();
        end
        rf_a3 = 5'd5;
        rf_wd = 32'hCAFEF00D;
        rf_a1 = 5'd5;
        #1;
        check("rf_same_cycle_old", rd1, 32'h105);
        tick();
        rf_we = 1'b0;
        #1;
        check("rf_write5", rd1, 32'hCAFEF00D);
        rf_a2 = 5'd4;
        #1;
        check("rf_reg4_unchanged", rd2, 32'h104);
        rf_a2 = 5'd6;
        #1;
        check("rf_reg6_unchanged", rd2, 32'h106);
        rf_a2 = 5'd0;
        #1;
        check("rf_reg0_unchanged", rd2, 32'h100);
        rf_a2 = 5'd7;
        #1;
        check("rf_reg7_unchanged", rd2, 32'h107);

        // WE3=0 must not write
        rf_a3 = 5'd5;
        rf_wd = 32'hBAD0BAD0;
        tick();
        check("rf_we0_hold", rd1, 32'hCAFEF00D);

        // Address 8 aliases register 0
        rf_we = 1'b1;
        rf_a3 = 5'd8;
        rf_wd = 32'h77;
        tick();
        rf_we = 1'b0;
        rf_a2 = 5'd0;
        rf_a1 = 5'd1;
        #1;
        check("rf_alias_rd2", rd2, 32'h77);
        check("rf_alias_reg1", rd1, 32'h101);
        rf_a1 = 5'd8;
        #1;
        check("rf_alias_rd1_a8", rd1, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_enabled_register
